// File: rtl/cheat_pkg.sv
// Shared types and constants for the cheat-code download loader.
package cheat_pkg;

   localparam int unsigned WORDS_PER_CODE = 8;
   localparam int unsigned CODE_BITS      = 129;
   localparam int unsigned CLK_BIT        = 128;
   localparam int unsigned HOLD_CYCLES    = 2;
   localparam int unsigned CLEAR_CYCLES   = 2;
   localparam int unsigned WORD_W         = 16;
   localparam int unsigned WIDX_W         = $clog2(WORDS_PER_CODE);
   localparam int unsigned HOLD_W         = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLEAR    = 3'd1,
      COLLECT  = 3'd2,
      ISSUE_HI = 3'd3,
      ISSUE_LO = 3'd4
   } cheat_state_e;

   // Download file words are little-endian; the code table wants big-endian.
   function automatic logic [WORD_W-1:0] be_word(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8]};
   endfunction

endpackage

// File: rtl/cheat_loader_if.sv
// Download-side handshake between the cheat file source and the loader.
interface cheat_loader_if;

   logic        dl_start;
   logic        dl_end;
   logic        wr;
   logic [15:0] wr_data;
   logic        wait_out;

   modport master (
      output dl_start, dl_end, wr, wr_data,
      input  wait_out
   );

   modport slave (
      input  dl_start, dl_end, wr, wr_data,
      output wait_out
   );

endinterface

// File: rtl/cheat_loader.sv
// Assembles 8-word cheat codes from a byte-swapped download stream and
// strobes each complete code into a downstream code table.
module cheat_loader
   import cheat_pkg::*;
#(
   parameter int unsigned MAX_CODES = 32,
   parameter int unsigned CW        = $clog2(MAX_CODES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   cheat_loader_if.slave        dl,
   output logic                 codes_clear,
   output logic [CODE_BITS-1:0] code,
   output logic [CW-1:0]        loaded_count,
   output logic                 overflow
);

   cheat_state_e              state_q, state_d;
   logic [HOLD_W-1:0]         hold_q, hold_d;
   logic [WIDX_W-1:0]         widx_q, widx_d;
   logic [CLK_BIT-1:0]        code_q, code_d;
   logic [CW-1:0]             count_q, count_d;
   logic                      ovf_q, ovf_d;
   logic                      end_pend_q, end_pend_d;
   logic                      clear_q, clear_d;
   logic                      wait_q, wait_d;
   logic                      clkbit_q, clkbit_d;

   localparam logic [HOLD_W-1:0] CLEAR_LAST = HOLD_W'(CLEAR_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [WIDX_W-1:0] WIDX_LAST  = WIDX_W'(WORDS_PER_CODE - 1);

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      widx_d     = widx_q;
      code_d     = code_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      end_pend_d = end_pend_q;

      unique case (state_q)
         IDLE: begin
            widx_d = '0;
         end

         CLEAR: begin
            if (dl.dl_end) begin
               state_d = IDLE;
               hold_d  = '0;
            end else if (hold_q == CLEAR_LAST) begin
               state_d = COLLECT;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         COLLECT: begin
            if (dl.dl_end) begin
               // A partial code is simply abandoned.
               state_d = IDLE;
               widx_d  = '0;
            end else if (dl.wr) begin
               for (int unsigned i = 0; i < WORDS_PER_CODE; i++) begin
                  if (widx_q == WIDX_W'(i)) begin
                     code_d[CLK_BIT-1-WORD_W*i -: WORD_W] = be_word(dl.wr_data);
                  end
               end
               if (widx_q == WIDX_LAST) begin
                  widx_d = '0;
                  if (count_q < CW'(MAX_CODES)) begin
                     state_d = ISSUE_HI;
                     hold_d  = '0;
                     count_d = count_q + CW'(1);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  widx_d = widx_q + WIDX_W'(1);
               end
            end
         end

         ISSUE_HI: begin
            if (dl.dl_end) end_pend_d = 1'b1;
            if (hold_q == HOLD_LAST) begin
               state_d = ISSUE_LO;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         ISSUE_LO: begin
            if (hold_q == HOLD_LAST) begin
               // A dl_end seen during the issue takes effect once it completes.
               state_d    = (end_pend_q || dl.dl_end) ? IDLE : COLLECT;
               hold_d     = '0;
               widx_d     = '0;
               end_pend_d = 1'b0;
            end else begin
               if (dl.dl_end) end_pend_d = 1'b1;
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            hold_d  = '0;
            widx_d  = '0;
         end
      endcase

      if (dl.dl_start) begin
         state_d    = CLEAR;
         hold_d     = '0;
         widx_d     = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
         end_pend_d = 1'b0;
      end

      clear_d  = (state_d == CLEAR);
      clkbit_d = (state_d == ISSUE_HI);
      wait_d   = (state_d == CLEAR) || (state_d == ISSUE_HI) || (state_d == ISSUE_LO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         widx_q     <= '0;
         code_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         end_pend_q <= 1'b0;
         clear_q    <= 1'b0;
         wait_q     <= 1'b0;
         clkbit_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         widx_q     <= widx_d;
         code_q     <= code_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         end_pend_q <= end_pend_d;
         clear_q    <= clear_d;
         wait_q     <= wait_d;
         clkbit_q   <= clkbit_d;
      end
   end

   assign dl.wait_out          = wait_q;
   assign codes_clear          = clear_q;
   assign code[CLK_BIT]        = clkbit_q;
   assign code[CLK_BIT-1:0]    = code_q;
   assign loaded_count         = count_q;
   assign overflow             = ovf_q;

endmodule
